// File: rtl/spi_word_sequencer_pkg.sv
// Shared definitions for the SPI word sequencer and the bench harness blocks
// that drive the core's register interface: state encodings, default sizing,
// and the wire-order bit index helper.
package spi_word_sequencer_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LEAD     = 3'd1;
    localparam logic [2:0] ST_SHIFT_HI = 3'd2;
    localparam logic [2:0] ST_SHIFT_LO = 3'd3;
    localparam logic [2:0] ST_TRAIL    = 3'd4;

    localparam int unsigned DEFAULT_SCK_HALF  = 2;
    localparam int unsigned DEFAULT_WORD_BITS = 64;
    localparam int unsigned DEFAULT_NUM_WORDS = 8;

    // Word bit position carried on the wire for a given (byte, bit) counter pair.
    // Bytes go in the configured order; bits inside a byte always go MSB first.
    function automatic int unsigned wire_bit_index(
        input int unsigned byte_cnt,
        input int unsigned bit_cnt,
        input int unsigned num_bytes,
        input bit          lsb_byte_first
    );
        int unsigned byte_pos;
        byte_pos = lsb_byte_first ? byte_cnt : (num_bytes - 1 - byte_cnt);
        return byte_pos * 8 + 7 - bit_cnt;
    endfunction

endpackage

// File: rtl/spi_word_sequencer_sck.sv
// SCK phase timer: a divide counter that emits a one-cycle strobe on the last
// cycle of every HALF-cycle phase while enabled, and clears when disabled.
module spi_sck_strobe
    import spi_word_sequencer_pkg::*;
#(
    parameter int unsigned HALF = DEFAULT_SCK_HALF
) (
    input  logic CLK,
    input  logic reset,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick_c = en && (cnt == CNT_W'(HALF - 1));

    // Phase counter: restarts at every strobe and whenever the sequencer is idle.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_word_sequencer.sv
// SPI mode-0 master that streams a programmable list of words out on COPI.
// Optional macro RX_CAPTURE_EN: when defined, CIPO is assembled into a receive
// buffer read through rd_data; otherwise rd_data is constant zero.
module spi_word_sequencer
    import spi_word_sequencer_pkg::*;
#(
    parameter int unsigned WORD_BITS      = DEFAULT_WORD_BITS,
    parameter int unsigned NUM_WORDS      = DEFAULT_NUM_WORDS,
    parameter int unsigned SCK_HALF       = DEFAULT_SCK_HALF,
    parameter bit          LSB_BYTE_FIRST = 1'b1
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_WORDS)-1:0]   wr_addr,
    input  logic [WORD_BITS-1:0]           wr_data,
    input  logic [$clog2(NUM_WORDS):0]     word_count,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           SCK,
    output logic                           CS,
    output logic                           COPI,
    input  logic                           CIPO,
    input  logic [$clog2(NUM_WORDS)-1:0]   rd_addr,
    output logic [WORD_BITS-1:0]           rd_data
);

    localparam int unsigned AW        = $clog2(NUM_WORDS);
    localparam int unsigned CW        = AW + 1;
    localparam int unsigned NUM_BYTES = WORD_BITS / 8;
    localparam int unsigned BYW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned IW        = $clog2(WORD_BITS);
    localparam int unsigned FIRST_IDX = wire_bit_index(0, 0, NUM_BYTES, LSB_BYTE_FIRST);

    logic [2:0]           state, state_nxt;
    logic                 busy_nxt, done_nxt, sck_nxt, cs_nxt, copi_nxt;
    logic [2:0]           bit_cnt, bit_cnt_nxt;
    logic [BYW-1:0]       byte_cnt, byte_cnt_nxt;
    logic [CW-1:0]        word_idx, word_idx_nxt;
    logic [CW-1:0]        word_total, word_total_nxt;
    logic [WORD_BITS-1:0] tx_word, tx_word_nxt;
    logic                 last_word_done, last_nxt;
    logic [WORD_BITS-1:0] tx_buf [NUM_WORDS];

    logic                 tick_c;
    logic                 word_end_c;
    logic [2:0]           adv_bit_c;
    logic [BYW-1:0]       adv_byte_c;
    logic [IW-1:0]        adv_idx_c;
    logic [CW-1:0]        next_word_c;
    logic [CW-1:0]        count_clamped_c;

    spi_sck_strobe #(.HALF(SCK_HALF)) u_sck_strobe (
        .CLK    (CLK),
        .reset  (reset),
        .en     (state != ST_IDLE),
        .tick_c (tick_c)
    );

    // TX word buffer; out-of-range addresses are dropped, contents survive reset.
    always_ff @(posedge CLK) begin
        if (wr_en && (CW'(wr_addr) < CW'(NUM_WORDS))) begin
            tx_buf[wr_addr] <= wr_data;
        end
    end

    // Counter advance and wire-index helpers for the falling-edge update.
    always_comb begin
        word_end_c      = (bit_cnt == 3'd7) && (byte_cnt == BYW'(NUM_BYTES - 1));
        adv_bit_c       = bit_cnt + 3'd1;
        adv_byte_c      = (bit_cnt == 3'd7) ? byte_cnt + BYW'(1) : byte_cnt;
        adv_idx_c       = IW'(wire_bit_index(32'(adv_byte_c), 32'(adv_bit_c),
                                             NUM_BYTES, LSB_BYTE_FIRST));
        next_word_c     = word_idx + CW'(1);
        count_clamped_c = (word_count > CW'(NUM_WORDS)) ? CW'(NUM_WORDS) : word_count;
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_nxt      = state;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        sck_nxt        = SCK;
        cs_nxt         = CS;
        copi_nxt       = COPI;
        bit_cnt_nxt    = bit_cnt;
        byte_cnt_nxt   = byte_cnt;
        word_idx_nxt   = word_idx;
        word_total_nxt = word_total;
        tx_word_nxt    = tx_word;
        last_nxt       = last_word_done;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt      = ST_LEAD;
                        busy_nxt       = 1'b1;
                        cs_nxt         = 1'b0;
                        sck_nxt        = 1'b0;
                        word_total_nxt = count_clamped_c;
                        word_idx_nxt   = '0;
                        bit_cnt_nxt    = '0;
                        byte_cnt_nxt   = '0;
                        last_nxt       = 1'b0;
                        tx_word_nxt    = tx_buf[AW'(0)];
                        copi_nxt       = tx_word_nxt[IW'(FIRST_IDX)];
                    end
                end
            end
            ST_LEAD: begin
                if (tick_c) begin
                    state_nxt = ST_SHIFT_HI;
                    sck_nxt   = 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (tick_c) begin
                    state_nxt = ST_SHIFT_LO;
                    sck_nxt   = 1'b0;
                    if (word_end_c) begin
                        bit_cnt_nxt  = '0;
                        byte_cnt_nxt = '0;
                        word_idx_nxt = next_word_c;
                        if (next_word_c < word_total) begin
                            tx_word_nxt = tx_buf[AW'(next_word_c)];
                            copi_nxt    = tx_word_nxt[IW'(FIRST_IDX)];
                        end else begin
                            last_nxt = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt  = adv_bit_c;
                        byte_cnt_nxt = adv_byte_c;
                        copi_nxt     = tx_word[adv_idx_c];
                    end
                end
            end
            ST_SHIFT_LO: begin
                if (tick_c) begin
                    if (last_word_done) begin
                        state_nxt = ST_TRAIL;
                        cs_nxt    = 1'b1;
                    end else begin
                        state_nxt = ST_SHIFT_HI;
                        sck_nxt   = 1'b1;
                    end
                end
            end
            ST_TRAIL: begin
                if (tick_c) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, output and datapath registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            SCK            <= 1'b0;
            CS             <= 1'b1;
            COPI           <= 1'b0;
            bit_cnt        <= '0;
            byte_cnt       <= '0;
            word_idx       <= '0;
            word_total     <= '0;
            tx_word        <= '0;
            last_word_done <= 1'b0;
        end else begin
            state          <= state_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            SCK            <= sck_nxt;
            CS             <= cs_nxt;
            COPI           <= copi_nxt;
            bit_cnt        <= bit_cnt_nxt;
            byte_cnt       <= byte_cnt_nxt;
            word_idx       <= word_idx_nxt;
            word_total     <= word_total_nxt;
            tx_word        <= tx_word_nxt;
            last_word_done <= last_nxt;
        end
    end

`ifdef RX_CAPTURE_EN
    logic                 rise_c;
    logic [IW-1:0]        cur_idx_c;
    logic [WORD_BITS-1:0] rx_word, rx_assembled_c;
    logic [WORD_BITS-1:0] rx_buf [NUM_WORDS];

    // Rising SCK event and the word with the current CIPO bit merged in.
    always_comb begin
        rise_c         = tick_c && ((state == ST_LEAD) ||
                                    ((state == ST_SHIFT_LO) && !last_word_done));
        cur_idx_c      = IW'(wire_bit_index(32'(byte_cnt), 32'(bit_cnt),
                                            NUM_BYTES, LSB_BYTE_FIRST));
        rx_assembled_c = rx_word;
        rx_assembled_c[cur_idx_c] = CIPO;
    end

    // RX assembly register, updated on every sampling edge.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rx_word <= '0;
        end else if (rise_c) begin
            rx_word <= rx_assembled_c;
        end
    end

    // Completed word lands in the RX buffer on its last sampling edge.
    always_ff @(posedge CLK) begin
        if (rise_c && word_end_c) begin
            rx_buf[AW'(word_idx)] <= rx_assembled_c;
        end
    end

    assign rd_data = rx_buf[rd_addr];
`else
    logic unused_rx;

    assign unused_rx = ^{CIPO, rd_addr};
    assign rd_data   = '0;
`endif

endmodule
